sdram_cmd_scheduler: RTL
========================

Name: sdram_cmd_scheduler

Overview:
Sits between two user requesters and the SDRAM_Controller command interface. It arbitrates round-robin between requester 0 and requester 1, and tracks the open row in each of the 4 banks (open-page policy). It issues ACTIVATE, PRECHARGE, READ and WRITE commands with tRP and tRCD spacing. It inserts periodic PRECHARGE_ALL + AUTO_REFRESH sequences, and refresh has priority over user requests.

Parameters:
REFRESH_INTERVAL, 780, cycles between refresh requests (counter period)
T_RP, 2, idle cycles after an accepted PRECHARGE / PRECHARGE_ALL
T_RCD, 2, idle cycles after an accepted ACTIVATE
T_RFC, 7, idle cycles after an accepted AUTO_REFRESH

Ports:
clk_crontroller  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 access request; held until req0_ready
req0_we  in  1  1 = write, 0 = read
req0_addr  in  22  {bank[21:20], row[19:8], col[7:0]}
req0_ready  out  1  one-cycle pulse: requester 0 access issued
req1_valid / req1_we / req1_addr / req1_ready  same as requester 0
cmd_valid  out  1  command presented to SDRAM_Controller
cmd_ready  in  1  controller accepts command when cmd_valid && cmd_ready
cmd_code  out  3  0 NOP, 1 ACTIVATE, 2 READ, 3 WRITE, 4 PRECHARGE, 5 PRECHARGE_ALL, 6 AUTO_REFRESH
cmd_bs  out  2  bank
cmd_row  out  12  row (ACTIVATE)
cmd_col  out  8  column (READ/WRITE)
cmd_src  out  1  requester owning current command
refresh_pending  out  1  refresh due, not yet started
busy  out  1  FSM not in IDLE

Behaviour:
- Reset, taking effect on the edge where rst=1:
  - all outputs 0, cmd_code=NOP
  - bank_open[3:0]=0, refresh counter=0, refresh_pending=0
  - last_grant=1, so requester 0 wins the first tie
  - FSM to IDLE
  - any in-flight command is abandoned; no ready pulse is issued for it.
- Refresh counter:
  - increments every cycle and wraps at REFRESH_INTERVAL-1.
  - on wrap, refresh_pending is set.
  - a second wrap while refresh_pending is set leaves it set; refresh debt is not accumulated.
- FSM states: IDLE, REF_PRE, REF_WAIT_RP, REF_CMD, REF_WAIT_RFC, PRE, WAIT_RP, ACT, WAIT_RCD, ACCESS.
- IDLE:
  - if refresh_pending, go to REF_PRE. This takes priority even when requests are valid.
  - otherwise, if any reqN_valid, latch the winner's addr, we and src, then go to the next state.
  - winner selection: the only valid requester wins; on a tie, the requester != last_grant wins.
  - next state: ACCESS on a row hit (bank open, same row); PRE if the bank is open on a different row; ACT if the bank is closed.
- Command states (REF_PRE, REF_CMD, PRE, ACT, ACCESS):
  - drive cmd_valid=1 with fields from the latched request.
  - hold cmd_valid and all cmd_* stable until cmd_ready.
  - advance on the accepting edge; cmd_valid=0 in the following cycle.
- Wait states (WAIT_RP, WAIT_RCD, REF_WAIT_RP, REF_WAIT_RFC):
  - cmd_valid=0, cmd_code=NOP for exactly T_x cycles.
  - then proceed: PRE→WAIT_RP→ACT→WAIT_RCD→ACCESS; REF_PRE→REF_WAIT_RP→REF_CMD→REF_WAIT_RFC→IDLE.
- Bank table updates, on the accepting edge only:
  - PRECHARGE clears bank_open[bs].
  - PRECHARGE_ALL clears all banks.
  - ACTIVATE sets bank_open[bs] and open_row[bs]=row.
  - refresh_pending clears when PRECHARGE_ALL is accepted.
- ACCESS:
  - cmd_code=3 if we, else 2.
  - on acceptance, reqN_ready pulses one cycle (the cycle after the acceptance edge), last_grant=src, FSM returns to IDLE.
  - minimum turnaround: IDLE is one cycle before the next arbitration.
- Requester rules: a requester that drops valid before ready is a protocol violation. The latched copy is used regardless.
- The refresh counter keeps running in every state. A refresh due mid-access waits for the current access to reach IDLE.
- busy=1 in all states except IDLE.

Test Plan:
1. Post-reset write, req0 addr={2'b01,12'h0AF,8'h10}, cmd_ready=1:
   - sequence ACT(bs=1,row=0x0AF) → 2 NOP cycles → WRITE(col=0x10).
   - req0_ready pulses once; bank_open=4'b0010.
2. Then a read from req1 at bank 1, row 0x0AF, col 0x20:
   - row hit: READ issued directly, no ACT or PRE.
   - req1_ready pulses once.
3. Then req0 at bank 1, row 0x123:
   - PRE(bs=1) → 2 NOP → ACT(row=0x123) → 2 NOP → READ.
   - open_row[1]=0x123.
4. req0 and req1 valid in the same cycle, repeated 4 times:
   - grants alternate 0,1,0,1 (after reset, req0 first).
5. REFRESH_INTERVAL=20, no requests:
   - refresh_pending rises at cycle 20.
   - PRECHARGE_ALL → 2 NOP → AUTO_REFRESH → 7 NOP.
   - bank_open=0; refresh_pending=1 with req0_valid held in the same cycle → refresh is served first.
6. Back-pressure and reset:
   - cmd_ready=0 for 5 cycles during ACT → cmd_* stay stable, then advance when cmd_ready=1.
   - rst asserted in WAIT_RCD → next cycle all outputs 0, busy=0, no ready pulse.

Source files
------------

// File: rtl/sdram_cmd_scheduler.sv
// SDRAM command scheduler: round-robin arbitration between two requesters,
// open-page bank tracking, tRP/tRCD/tRFC spacing and periodic refresh.
module sdram_cmd_scheduler #(
    parameter int REFRESH_INTERVAL = 780,
    parameter int T_RP             = 2,
    parameter int T_RCD            = 2,
    parameter int T_RFC            = 7
) (
    input  logic        clk_crontroller,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [21:0] req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [21:0] req1_addr,
    output logic        req1_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_code,
    output logic [1:0]  cmd_bs,
    output logic [11:0] cmd_row,
    output logic [7:0]  cmd_col,
    output logic        cmd_src,
    output logic        refresh_pending,
    output logic        busy
);

    localparam int RCW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_AREF = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_REF_PRE, S_REF_WAIT_RP, S_REF_CMD, S_REF_WAIT_RFC,
        S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_ACCESS
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [21:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic             src_q, src_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       bank_open_q, bank_open_d;
    logic [3:0][11:0] open_row_q, open_row_d;
    logic [1:0]       rdy_q, rdy_d;
    logic [RCW-1:0]   ref_cnt_q;
    logic             ref_pend_q;

    logic             cmd_valid_q, cmd_src_q, busy_q;
    logic [2:0]       cmd_code_q;
    logic [1:0]       cmd_bs_q;
    logic [11:0]      cmd_row_q;
    logic [7:0]       cmd_col_q;

    // A requester whose ready is pulsing this cycle is still holding valid for
    // the access just served, so it is masked out of this arbitration.
    logic        v0, v1, gnt, accept, ref_wrap;
    logic [21:0] win_addr;
    logic [1:0]  win_bank;

    assign v0       = req0_valid & ~rdy_q[0];
    assign v1       = req1_valid & ~rdy_q[1];
    assign gnt      = (v0 & v1) ? ~last_grant_q : v1;
    assign win_addr = gnt ? req1_addr : req0_addr;
    assign win_bank = win_addr[21:20];
    assign accept   = cmd_valid_q & cmd_ready;
    assign ref_wrap = (ref_cnt_q == RCW'(REFRESH_INTERVAL - 1));

    // Next-state, request latch and bank table updates
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        addr_d       = addr_q;
        we_d         = we_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        bank_open_d  = bank_open_q;
        open_row_d   = open_row_q;
        rdy_d        = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (ref_pend_q) begin
                    state_d = S_REF_PRE;
                end else if (v0 | v1) begin
                    addr_d = win_addr;
                    we_d   = gnt ? req1_we : req0_we;
                    src_d  = gnt;
                    if (!bank_open_q[win_bank])                           state_d = S_ACT;
                    else if (open_row_q[win_bank] == win_addr[19:8])      state_d = S_ACCESS;
                    else                                                  state_d = S_PRE;
                end
            end
            S_REF_PRE: if (accept) begin
                bank_open_d = 4'b0000;
                wait_d      = 8'(T_RP - 1);
                state_d     = S_REF_WAIT_RP;
            end
            S_REF_WAIT_RP: begin
                if (wait_q == 8'd0) state_d = S_REF_CMD;
                else                wait_d  = wait_q - 8'd1;
            end
            S_REF_CMD: if (accept) begin
                wait_d  = 8'(T_RFC - 1);
                state_d = S_REF_WAIT_RFC;
            end
            S_REF_WAIT_RFC: begin
                if (wait_q == 8'd0) state_d = S_IDLE;
                else                wait_d  = wait_q - 8'd1;
            end
            S_PRE: if (accept) begin
                bank_open_d[addr_q[21:20]] = 1'b0;
                wait_d  = 8'(T_RP - 1);
                state_d = S_WAIT_RP;
            end
            S_WAIT_RP: begin
                if (wait_q == 8'd0) state_d = S_ACT;
                else                wait_d  = wait_q - 8'd1;
            end
            S_ACT: if (accept) begin
                bank_open_d[addr_q[21:20]] = 1'b1;
                open_row_d[addr_q[21:20]]  = addr_q[19:8];
                wait_d  = 8'(T_RCD - 1);
                state_d = S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                if (wait_q == 8'd0) state_d = S_ACCESS;
                else                wait_d  = wait_q - 8'd1;
            end
            S_ACCESS: if (accept) begin
                rdy_d[src_q] = 1'b1;
                last_grant_d = src_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state plus registered command outputs decoded from the next state
    always_ff @(posedge clk_crontroller) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
            bank_open_q  <= '0;
            open_row_q   <= '0;
            rdy_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= CMD_NOP;
            cmd_bs_q     <= '0;
            cmd_row_q    <= '0;
            cmd_col_q    <= '0;
            cmd_src_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            bank_open_q  <= bank_open_d;
            open_row_q   <= open_row_d;
            rdy_q        <= rdy_d;
            busy_q       <= (state_d != S_IDLE);
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= CMD_NOP;
            cmd_bs_q     <= '0;
            cmd_row_q    <= '0;
            cmd_col_q    <= '0;
            cmd_src_q    <= 1'b0;
            case (state_d)
                S_REF_PRE: begin
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= CMD_PREA;
                end
                S_REF_CMD: begin
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= CMD_AREF;
                end
                S_PRE: begin
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= CMD_PRE;
                    cmd_bs_q    <= addr_d[21:20];
                    cmd_src_q   <= src_d;
                end
                S_ACT: begin
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= CMD_ACT;
                    cmd_bs_q    <= addr_d[21:20];
                    cmd_row_q   <= addr_d[19:8];
                    cmd_src_q   <= src_d;
                end
                S_ACCESS: begin
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= we_d ? CMD_WR : CMD_RD;
                    cmd_bs_q    <= addr_d[21:20];
                    cmd_col_q   <= addr_d[7:0];
                    cmd_src_q   <= src_d;
                end
                default: ;
            endcase
        end
    end

    // Free-running refresh timer; a new wrap wins over a same-cycle clear
    always_ff @(posedge clk_crontroller) begin
        if (rst) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + RCW'(1);
            if (ref_wrap)                          ref_pend_q <= 1'b1;
            else if (state_q == S_REF_PRE && accept) ref_pend_q <= 1'b0;
        end
    end

    assign req0_ready      = rdy_q[0];
    assign req1_ready      = rdy_q[1];
    assign cmd_valid       = cmd_valid_q;
    assign cmd_code        = cmd_code_q;
    assign cmd_bs          = cmd_bs_q;
    assign cmd_row         = cmd_row_q;
    assign cmd_col         = cmd_col_q;
    assign cmd_src         = cmd_src_q;
    assign refresh_pending = ref_pend_q;
    assign busy            = busy_q;

endmodule
